sample_path_proc: RTL
=====================

Name: sample_path_proc

Overview:
Parametrised sampling and processing stage between the ADC SPI interface (spi2adc) and the DAC SPI interface (spi2dac). It generates the sampling tick internally and accepts each converted sample. It processes the sample through a circular delay buffer in one of four modes, then issues a one-cycle DAC load strobe with the result. It replaces the fixed 10kHz tick plus all-pass processor pairing in top-level lab designs.

Parameters:
DATA_W, 10, sample width in bits (ADC and DAC).
DEPTH, 1024, delay buffer entries; power of two, ADDR_W = log2(DEPTH).
DIV_N, 4999, tick period minus one in sysclk cycles (4999 gives 10kHz at 50MHz).

Ports:
sysclk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
en  in  1  tick generator enable.
mode  in  2  0 pass, 1 delay, 2 echo, 3 invert.
delay  in  ADDR_W  delay in samples.
adc_data  in  DATA_W  sample from spi2adc.
adc_valid  in  1  one-cycle strobe from spi2adc; adc_data is valid in that cycle.
adc_start  out  1  one-cycle conversion start to spi2adc.
dac_data  out  DATA_W  processed sample to spi2dac.
dac_load  out  1  one-cycle load strobe to spi2dac.
overrun  out  1  sticky: a tick arrived while still waiting for adc_valid.

Behaviour:
- Reset (async, immediate): adc_start=0, dac_load=0, dac_data=2^(DATA_W-1) (midscale), overrun=0, divider=0, wr_ptr=0, fill=0, pending=0, state IDLE. RAM contents are not reset.
- Tick divider:
  - en=1: counter counts 0..DIV_N and wraps.
  - adc_start=1 for exactly one cycle when the counter equals DIV_N. Period is DIV_N+1 cycles.
  - en=0: counter holds and no ticks occur. The first tick after re-enable follows the remaining count.
- FSM states: IDLE, WAIT_VALID, READ, OUTPUT.
  - IDLE: tick -> WAIT_VALID.
  - WAIT_VALID: adc_valid -> READ, and the accept actions below happen in that cycle. A tick in this state sets overrun and the state is unchanged.
  - READ: always -> OUTPUT next cycle.
  - OUTPUT: dac_data registered and dac_load=1 this cycle. Next state is WAIT_VALID if pending=1 (pending cleared), else IDLE.
  - A tick during READ or OUTPUT sets pending and does not set overrun.
  - adc_valid outside WAIT_VALID is ignored: no write and no output.
- Accept cycle (adc_valid in WAIT_VALID):
  - Latch x=adc_data, mode and delay.
  - Write x to RAM[wr_ptr].
  - Issue synchronous read of RAM[(wr_ptr - delay) mod DEPTH].
  - wr_ptr increments mod DEPTH. fill increments, saturating at DEPTH.
- Delayed sample d, resolved in READ:
  - delay=0: d=x (forwarded; no RAM read used).
  - delay>fill-1, using fill before the increment, i.e. the sample was never written: d=midscale.
  - Otherwise d=RAM read data (read-before-write semantics on the same address are irrelevant because delay=0 is forwarded).
- Arithmetic, computed in OUTPUT from registered x and d:
  - mode 0: x.
  - mode 1: d.
  - mode 2: (x+d)>>1 with a DATA_W+1-bit sum, floor, no overflow.
  - mode 3: (2^DATA_W-1)-x.
- Latency: adc_valid at cycle A -> dac_load and new dac_data at cycle A+2. dac_data holds its value until the next OUTPUT.
- Changing mode or delay between samples takes effect at the next accept. It never clears fill or the RAM.
- Reset mid-operation: the FSM returns to IDLE at once, any in-flight sample is dropped, and no dac_load is issued.
- overrun is cleared only by rst.

Test Plan:
- Reset then release with DIV_N=9, en=1 -> adc_start pulses every 10 cycles. dac_data=512 until the first output, overrun=0.
- mode 0: adc_valid with adc_data=300 three cycles after adc_start -> dac_load exactly 2 cycles after adc_valid, dac_data=300. mode 3, sample 300 -> 723.
- mode 1, delay=3: feed samples 10,20,30,40,50 -> outputs 512,512,512,10,20. Then set delay=0: next sample 60 -> 60.
- mode 2, delay=1: samples 1000 then 1023 -> outputs (1000+512)>>1=756, then (1023+1000)>>1=1011.
- Withhold adc_valid across two ticks -> overrun=1 and stays 1. A later adc_valid still produces one dac_load. Tick during READ/OUTPUT -> no overrun, FSM goes to WAIT_VALID.
- Assert rst in the cycle after adc_valid -> no dac_load, dac_data=512. After release, fill=0, so a delay=2 output is midscale. With en=0, no adc_start for 50 cycles.

Source files
------------

// File: rtl/sample_path_proc_if.sv
// sample_path_proc_if: ADC/DAC sample handshake between sample_path_proc (master) and the SPI converter blocks (slave)
//   adc_start  master->slave  one-cycle conversion start
//   adc_data   slave->master  converted sample, valid with adc_valid
//   adc_valid  slave->master  one-cycle sample strobe
//   dac_data   master->slave  processed sample
//   dac_load   master->slave  one-cycle DAC load strobe
interface sample_path_proc_if #(parameter int DATA_W = 10);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              adc_start;
  logic [DATA_W-1:0] dac_data;
  logic              dac_load;
  modport master(input adc_data, adc_valid, output adc_start, dac_data, dac_load);
  modport slave(output adc_data, adc_valid, input adc_start, dac_data, dac_load);
endinterface

// File: rtl/sample_path_proc.sv
// sample_path_proc: tick generation, ADC sample capture, delay-buffer processing (pass/delay/echo/invert) and DAC load
//   sysclk  system clock
//   rst     asynchronous active-high reset
//   en      tick generator enable
//   mode    0 pass, 1 delay, 2 echo, 3 invert
//   delay   delay in samples
//   io      ADC/DAC handshake (adc_start, adc_data, adc_valid, dac_data, dac_load)
//   overrun sticky: a tick arrived while still waiting for adc_valid
module sample_path_proc #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DIV_N  = 4999,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CW     = $clog2(DIV_N + 1)
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] delay,
  sample_path_proc_if.master io,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, WAIT_VALID, READ, OUTPUT} state_t;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  state_t              state, nxt;
  logic [CW-1:0]       cnt;
  logic                tick, acc, pending, pend_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     fill;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   rd_data, x_r, d, res;
  logic [DATA_W:0]     sum;
  logic [1:0]          mode_r;
  logic                fwd_r, never_r;
  assign tick         = en && cnt == CW'(DIV_N);
  assign acc          = state == WAIT_VALID && io.adc_valid;
  assign io.adc_start = tick;
  assign io.dac_load  = state == OUTPUT;
  // delay 0 bypasses the RAM; a tap older than anything written reads as midscale
  assign d   = fwd_r ? x_r : (never_r ? MID : rd_data);
  assign sum = {1'b0, x_r} + {1'b0, d};
  assign res = mode_r == 2'd0 ? x_r : mode_r == 2'd1 ? d : mode_r == 2'd2 ? sum[DATA_W:1] : ~x_r;
  // a tick while a sample is still in flight is remembered so the next
  // conversion result is accepted without waiting for another tick
  always_comb begin
    nxt      = state;
    pend_nxt = pending;
    case (state)
      IDLE:       nxt = tick ? WAIT_VALID : IDLE;
      WAIT_VALID: nxt = io.adc_valid ? READ : WAIT_VALID;
      READ: begin
        nxt      = OUTPUT;
        pend_nxt = pending || tick;
      end
      default: begin
        nxt      = (pending || tick) ? WAIT_VALID : IDLE;
        pend_nxt = 1'b0;
      end
    endcase
  end
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      state       <= IDLE;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      wr_ptr      <= '0;
      fill        <= '0;
      x_r         <= '0;
      mode_r      <= '0;
      fwd_r       <= 1'b0;
      never_r     <= 1'b0;
      io.dac_data <= MID;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      state   <= nxt;
      pending <= pend_nxt;
      if (tick && state == WAIT_VALID) overrun <= 1'b1;
      if (acc) begin
        x_r     <= io.adc_data;
        mode_r  <= mode;
        fwd_r   <= delay == '0;
        never_r <= {1'b0, delay} >= fill;
        wr_ptr  <= wr_ptr + 1'b1;
        if (fill != (ADDR_W+1)'(DEPTH)) fill <= fill + 1'b1;
      end
      if (state == READ) io.dac_data <= res;
    end
  end
  always_ff @(posedge sysclk) begin
    if (acc) begin
      ram[wr_ptr] <= io.adc_data;
      rd_data     <= ram[wr_ptr - delay];
    end
  end
endmodule
